// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_types_pkg
//  Description : Shared CPU types: data word, RAM port state and the
//                data-memory responder FSM state and error word.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  // Native data word of the CPU.
  typedef logic [31:0] word_t;

  // State reported by the RAM port.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Data-memory responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // Value returned on dmemload when an access fails or times out.
  localparam word_t DMEM_ERR_WORD = 32'hBAD1_BAD1;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/dmem_load_buf.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_load_buf
//  Description : One-entry load buffer {valid, word address, data} with
//                combinational lookup, fill on a successful RAM load and
//                invalidate. Only instantiated when DMEM_LOAD_BUF_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_load_buf #(
  parameter int WADDR_W = 30,
  parameter int DATA_W  = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [WADDR_W-1:0] i_lookup_waddr,
  output logic               o_hit,
  output logic [DATA_W-1:0]  o_data,
  input  logic               i_fill,
  input  logic [WADDR_W-1:0] i_fill_waddr,
  input  logic [DATA_W-1:0]  i_fill_data,
  input  logic               i_inval
);

  logic               r_valid;
  logic [WADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0]  r_data;

  // Entry update: invalidate wins over fill so a stale line can never survive.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= 1'b0;
      r_waddr <= '0;
      r_data  <= '0;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_waddr <= i_fill_waddr;
      r_data  <= i_fill_data;
    end
  end

  assign o_hit  = r_valid && (r_waddr == i_lookup_waddr);
  assign o_data = r_data;

endmodule : dmem_load_buf
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Far end of the MEM-stage dmemREN/dmemWEN request. Runs one
//                load or store at a time against the RAM port and returns a
//                one-cycle dhit with dmemload. RAM ERROR or a REQ timeout
//                returns DMEM_ERR_WORD and sets the sticky memerr flag.
//                Optional macro DMEM_LOAD_BUF_EN adds a one-entry load buffer
//                that answers repeated loads without a RAM access.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [DATA_W-1:0] dmemstore,
  input  logic              halt,
  output logic              dhit,
  output logic [DATA_W-1:0] dmemload,
  output logic              memerr,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate
);

  // REQ cycle index at which the access is abandoned (REQ lasts TIMEOUT_CYC cycles).
  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  dmem_state_t       r_state;
  logic [7:0]        r_cnt;
  logic              w_req;
  logic              w_timeout;
  logic              w_fail;
  logic              w_buf_hit;
  logic [DATA_W-1:0] w_buf_data;

  assign w_req     = (dmemREN | dmemWEN) & ~halt;
  assign w_timeout = (r_cnt == c_TIMEOUT_LAST);
  // ACCESS takes precedence: a response on the last allowed cycle still succeeds.
  assign w_fail    = (r_state == REQ) && (ramstate != ACCESS) &&
                     ((ramstate == ERROR) || w_timeout);

`ifdef DMEM_LOAD_BUF_EN
  logic w_buf_fill;
  logic w_buf_inval;

  assign w_buf_fill  = (r_state == REQ) && (ramstate == ACCESS) && ramREN;
  assign w_buf_inval = ((r_state == IDLE) && w_req && dmemWEN) || w_fail;

  dmem_load_buf #(
    .WADDR_W (ADDR_W - 2),
    .DATA_W  (DATA_W)
  ) u_load_buf (
    .CLK            (CLK),
    .nRST           (nRST),
    .i_lookup_waddr (dmemaddr[ADDR_W-1:2]),
    .o_hit          (w_buf_hit),
    .o_data         (w_buf_data),
    .i_fill         (w_buf_fill),
    .i_fill_waddr   (ramaddr[ADDR_W-1:2]),
    .i_fill_data    (ramload),
    .i_inval        (w_buf_inval)
  );
`else
  assign w_buf_hit  = 1'b0;
  assign w_buf_data = '0;
`endif

  // Request FSM with registered strobes, completion pulse and load data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      dhit     <= 1'b0;
      dmemload <= '0;
      memerr   <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      dhit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            if (!dmemWEN && w_buf_hit) begin
              // Buffered load: answer directly, RAM is never touched.
              dhit     <= 1'b1;
              dmemload <= w_buf_data;
              r_state  <= DONE;
            end else begin
              // Store wins when both requests are raised together.
              r_cnt    <= '0;
              ramREN   <= ~dmemWEN;
              ramWEN   <= dmemWEN;
              ramaddr  <= dmemaddr;
              ramstore <= dmemstore;
              r_state  <= REQ;
            end
          end
        end
        REQ: begin
          if (ramstate == ACCESS) begin
            if (ramREN) begin
              dmemload <= ramload;
            end
            dhit    <= 1'b1;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            r_state <= DONE;
          end else if (w_fail) begin
            dmemload <= DATA_W'(DMEM_ERR_WORD);
            memerr   <= 1'b1;
            dhit     <= 1'b1;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            r_state  <= DONE;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. A small RAM model
//                answers strobes; expected dmemload values go into a queue
//                when a request is driven and are popped at dhit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      dmemREN, dmemWEN, halt;
  word_t     dmemaddr, dmemstore, ramload;
  ramstate_t ramstate;
  logic      dhit, memerr, ramREN, ramWEN;
  word_t     dmemload, ramaddr, ramstore;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t sb_q[$];
  word_t m_load   = '0;

  always #5 CLK = ~CLK;

  dmem_responder #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(255)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
    .dhit(dhit), .dmemload(dmemload), .memerr(memerr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  // Drives one request from the start of cycle 0 (a negedge) and plays the RAM:
  // BUSY for 'busy' strobe cycles, then 'fin'. Returns observations only.
  task automatic do_access(input logic rd, input logic wr, input word_t addr, input word_t wdata,
                           input int busy, input ramstate_t fin, input word_t rdata,
                           output int lat, output int ren_n, output int wen_n, output int hit_n,
                           output word_t seen_addr, output word_t seen_store, output word_t got);
    int  strobes;
    bit  done;
    lat = -1; ren_n = 0; wen_n = 0; hit_n = 0; strobes = 0; done = 0;
    seen_addr = '0; seen_store = '0; got = '0;
    dmemREN = rd; dmemWEN = wr; dmemaddr = addr; dmemstore = wdata;
    for (int c = 1; c <= 400 && !done; c++) begin
      @(negedge CLK);
      ramload = rdata;
      if (ramREN || ramWEN) begin
        if (strobes == 0) begin seen_addr = ramaddr; seen_store = ramstore; end
        if (ramREN) ren_n++;
        if (ramWEN) wen_n++;
        ramstate = (strobes < busy) ? BUSY : fin;
        strobes++;
      end else begin
        ramstate = FREE;
      end
      if (dhit) begin
        lat = c; got = dmemload; hit_n++; done = 1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
      end
    end
    @(negedge CLK);
    ramstate = FREE;
    if (dhit) hit_n++;
    if (ramREN || ramWEN) ren_n += 100;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    @(negedge CLK);
    n_checks++; if (dhit !== 1'b0) begin n_fail++; $display("FAIL reset_dhit: got %b want 0", dhit); end
    n_checks++; if (dmemload !== 32'h0) begin n_fail++; $display("FAIL reset_dmemload: got %h want 0", dmemload); end
    n_checks++; if (memerr !== 1'b0) begin n_fail++; $display("FAIL reset_memerr: got %b want 0", memerr); end
    n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL reset_ramREN: got %b want 0", ramREN); end
    n_checks++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL reset_ramWEN: got %b want 0", ramWEN); end
    n_checks++; if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL reset_ramaddr: got %h want 0", ramaddr); end
    n_checks++; if (ramstore !== 32'h0) begin n_fail++; $display("FAIL reset_ramstore: got %h want 0", ramstore); end
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_load();
    int lat, rn, wn, hn; word_t sa, ss, got, exp;
    sb_q.push_back(32'h1234_5678);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, ACCESS, 32'h1234_5678, lat, rn, wn, hn, sa, ss, got);
    m_load = 32'h1234_5678;
    exp = sb_q.pop_front();
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL load_latency: got %0d want 2", lat); end
    n_checks++; if (rn !== 1) begin n_fail++; $display("FAIL load_ramREN_cycles: got %0d want 1", rn); end
    n_checks++; if (wn !== 0) begin n_fail++; $display("FAIL load_ramWEN_cycles: got %0d want 0", wn); end
    n_checks++; if (sa !== 32'h40) begin n_fail++; $display("FAIL load_ramaddr: got %h want 40", sa); end
    n_checks++; if (hn !== 1) begin n_fail++; $display("FAIL load_dhit_count: got %0d want 1", hn); end
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL load_data: got %h want %h", got, exp); end
  endtask

  task automatic test_store();
    int lat, rn, wn, hn; word_t sa, ss, got, exp;
    sb_q.push_back(m_load);
    do_access(1'b0, 1'b1, 32'h80, 32'hDEAD_BEEF, 3, ACCESS, 32'h7777_7777, lat, rn, wn, hn, sa, ss, got);
    exp = sb_q.pop_front();
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL store_latency: got %0d want 5", lat); end
    n_checks++; if (wn !== 4) begin n_fail++; $display("FAIL store_ramWEN_cycles: got %0d want 4", wn); end
    n_checks++; if (rn !== 0) begin n_fail++; $display("FAIL store_ramREN_cycles: got %0d want 0", rn); end
    n_checks++; if (ss !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_ramstore: got %h want deadbeef", ss); end
    n_checks++; if (sa !== 32'h80) begin n_fail++; $display("FAIL store_ramaddr: got %h want 80", sa); end
    n_checks++; if (hn !== 1) begin n_fail++; $display("FAIL store_dhit_count: got %0d want 1", hn); end
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL store_dmemload_kept: got %h want %h", got, exp); end
  endtask

  task automatic test_both_and_halt();
    int lat, rn, wn, hn, bad; word_t sa, ss, got, exp;
    sb_q.push_back(m_load);
    do_access(1'b1, 1'b1, 32'h90, 32'h5555_AAAA, 0, ACCESS, 32'h1111_2222, lat, rn, wn, hn, sa, ss, got);
    exp = sb_q.pop_front();
    n_checks++; if (wn !== 1 || rn !== 0) begin n_fail++; $display("FAIL both_store_wins: got wen=%0d ren=%0d want wen=1 ren=0", wn, rn); end
    n_checks++; if (ss !== 32'h5555_AAAA) begin n_fail++; $display("FAIL both_ramstore: got %h want 5555aaaa", ss); end
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL both_dmemload_kept: got %h want %h", got, exp); end
    // Held request under halt must not reach the RAM.
    bad = 0;
    halt = 1'b1; dmemREN = 1'b1; dmemaddr = 32'h44;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (ramREN || ramWEN || dhit) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL halt_blocks: got %0d active cycles want 0", bad); end
    halt = 1'b0;
    sb_q.push_back(32'hCAFE_0044);
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 0, ACCESS, 32'hCAFE_0044, lat, rn, wn, hn, sa, ss, got);
    m_load = 32'hCAFE_0044;
    exp = sb_q.pop_front();
    n_checks++; if (lat !== 2 || rn !== 1) begin n_fail++; $display("FAIL halt_release: got lat=%0d ren=%0d want lat=2 ren=1", lat, rn); end
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL halt_release_data: got %h want %h", got, exp); end
  endtask

  task automatic test_timeout_error();
    int lat, rn, wn, hn; word_t sa, ss, got, exp;
    n_checks++; if (memerr !== 1'b0) begin n_fail++; $display("FAIL pre_timeout_memerr: got %b want 0", memerr); end
    sb_q.push_back(32'hBAD1_BAD1);
    do_access(1'b1, 1'b0, 32'hA0, 32'h0, 100000, BUSY, 32'h0, lat, rn, wn, hn, sa, ss, got);
    m_load = 32'hBAD1_BAD1;
    exp = sb_q.pop_front();
    n_checks++; if (lat !== 256) begin n_fail++; $display("FAIL timeout_latency: got %0d want 256", lat); end
    n_checks++; if (rn !== 255) begin n_fail++; $display("FAIL timeout_ramREN_cycles: got %0d want 255", rn); end
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL timeout_data: got %h want %h", got, exp); end
    n_checks++; if (memerr !== 1'b1) begin n_fail++; $display("FAIL timeout_memerr: got %b want 1", memerr); end
    // A successful load afterwards must not clear the sticky flag.
    sb_q.push_back(32'h0BAD_F00D);
    do_access(1'b1, 1'b0, 32'hB0, 32'h0, 2, ACCESS, 32'h0BAD_F00D, lat, rn, wn, hn, sa, ss, got);
    m_load = 32'h0BAD_F00D;
    exp = sb_q.pop_front();
    n_checks++; if (got !== exp || lat !== 4) begin n_fail++; $display("FAIL busy_load: got %h lat=%0d want %h lat=4", got, lat, exp); end
    n_checks++; if (memerr !== 1'b1) begin n_fail++; $display("FAIL memerr_sticky: got %b want 1", memerr); end
    // RAM ERROR on a store: error word is returned.
    sb_q.push_back(32'hBAD1_BAD1);
    do_access(1'b0, 1'b1, 32'hC0, 32'h1357_9BDF, 1, ERROR, 32'h0, lat, rn, wn, hn, sa, ss, got);
    m_load = 32'hBAD1_BAD1;
    exp = sb_q.pop_front();
    n_checks++; if (lat !== 3 || got !== exp) begin n_fail++; $display("FAIL error_store: got %h lat=%0d want %h lat=3", got, lat, exp); end
  endtask

  task automatic test_back_to_back();
    int lat, rn, wn, hn; word_t sa, ss, got, exp;
    word_t addrs[3] = '{32'h100, 32'h104, 32'h108};
    word_t datas[3] = '{32'hA5A5_0001, 32'h5A5A_0002, 32'h0F0F_0003};
    int    busys[3] = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(datas[i]);
      do_access(1'b1, 1'b0, addrs[i], 32'h0, busys[i], ACCESS, datas[i], lat, rn, wn, hn, sa, ss, got);
      m_load = datas[i];
      exp = sb_q.pop_front();
      n_checks++; if (got !== exp || sa !== addrs[i]) begin n_fail++; $display("FAIL b2b_%0d: got data=%h addr=%h want data=%h addr=%h", i, got, sa, exp, addrs[i]); end
      n_checks++; if (lat !== 2 + busys[i] || hn !== 1) begin n_fail++; $display("FAIL b2b_timing_%0d: got lat=%0d hits=%0d want lat=%0d hits=1", i, lat, hn, 2 + busys[i]); end
    end
  endtask

`ifdef DMEM_LOAD_BUF_EN
  task automatic test_load_buf();
    int lat, rn, wn, hn; word_t sa, ss, got, exp;
    sb_q.push_back(32'h1234_5678);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, ACCESS, 32'h1234_5678, lat, rn, wn, hn, sa, ss, got);
    exp = sb_q.pop_front();
    n_checks++; if (rn !== 1 || got !== exp) begin n_fail++; $display("FAIL buf_fill: got ren=%0d data=%h want ren=1 data=%h", rn, got, exp); end
    sb_q.push_back(32'h1234_5678);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, ACCESS, 32'hFFFF_0000, lat, rn, wn, hn, sa, ss, got);
    exp = sb_q.pop_front();
    n_checks++; if (lat !== 1 || rn !== 0) begin n_fail++; $display("FAIL buf_hit_timing: got lat=%0d ren=%0d want lat=1 ren=0", lat, rn); end
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL buf_hit_data: got %h want %h", got, exp); end
    sb_q.push_back(32'h1234_5678);
    do_access(1'b0, 1'b1, 32'h40, 32'h2468_ACE0, 0, ACCESS, 32'h0, lat, rn, wn, hn, sa, ss, got);
    exp = sb_q.pop_front();
    n_checks++; if (wn !== 1 || got !== exp) begin n_fail++; $display("FAIL buf_store: got wen=%0d data=%h want wen=1 data=%h", wn, got, exp); end
    sb_q.push_back(32'h2468_ACE0);
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 0, ACCESS, 32'h2468_ACE0, lat, rn, wn, hn, sa, ss, got);
    m_load = 32'h2468_ACE0;
    exp = sb_q.pop_front();
    n_checks++; if (rn !== 1 || lat !== 2 || got !== exp) begin n_fail++; $display("FAIL buf_invalidated: got ren=%0d lat=%0d data=%h want ren=1 lat=2 data=%h", rn, lat, got, exp); end
  endtask
`endif

  task automatic test_reset_mid();
    int lat, rn, wn, hn, bad; word_t sa, ss, got, exp;
    dmemREN = 1'b1; dmemaddr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      ramstate = (ramREN || ramWEN) ? BUSY : FREE;
    end
    n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL midreset_setup: got ramREN=%b want 1", ramREN); end
    #2 nRST = 1'b0; dmemREN = 1'b0; ramstate = FREE;
    #1;
    n_checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin n_fail++; $display("FAIL midreset_strobes: got ren=%b wen=%b want 0 0", ramREN, ramWEN); end
    @(negedge CLK);
    nRST = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (dhit || ramREN || ramWEN) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d active cycles want 0", bad); end
    n_checks++; if (memerr !== 1'b0 || dmemload !== 32'h0) begin n_fail++; $display("FAIL midreset_cleared: got memerr=%b dmemload=%h want 0 0", memerr, dmemload); end
    m_load = '0;
    sb_q.push_back(32'h3C3C_C3C3);
    do_access(1'b1, 1'b0, 32'h204, 32'h0, 0, ACCESS, 32'h3C3C_C3C3, lat, rn, wn, hn, sa, ss, got);
    exp = sb_q.pop_front();
    n_checks++; if (lat !== 2 || got !== exp) begin n_fail++; $display("FAIL midreset_idle: got lat=%0d data=%h want lat=2 data=%h", lat, got, exp); end
  endtask

  initial begin
    dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    dmemaddr = '0; dmemstore = '0; ramload = '0; ramstate = FREE; nRST = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_both_and_halt();
    test_timeout_error();
    test_back_to_back();
`ifdef DMEM_LOAD_BUF_EN
    test_load_buf();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_dmem_responder
`default_nettype wire
